// File: rtl/gf2m8_pkg.sv
// GF(2^8) field constants and the reduced product over p(x)=0x11D.
// Shared by the lane multiplier and its core.
package gf2m8_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam logic [7:0] GF_ALPHA = 8'h02;
  localparam logic [7:0] GF_ONE   = 8'h01;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    // fold bits 14..8 back down through the field polynomial
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'(GF_POLY) << (i - 8));
    return p[7:0];
  endfunction

endpackage

// File: rtl/gf2m8_mul_core.sv
// Single combinational GF(2^8) multiply.
// No tables and no state.
module gf2m8_mul_core
  import gf2m8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  assign p = gf_mul(a, b);

endmodule

// File: rtl/gf2m8_mul_lanes.sv
// LANES GF(2^8) products of shared x, registered behind ena.
// GF2M8_MUL_PIPE2_EN adds an operand stage (latency 2).
module gf2m8_mul_lanes
  import gf2m8_pkg::*;
#(
  parameter int LANES = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ena,
  input  logic [7:0]           x,
  input  logic [8*LANES-1:0]   y,
  output logic [8*LANES-1:0]   z
);

  logic [7:0]         xs;
  logic [8*LANES-1:0] ys;
  logic [8*LANES-1:0] prod;
  logic               cap;

`ifdef GF2M8_MUL_PIPE2_EN
  logic ena_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      xs    <= '0;
      ys    <= '0;
      ena_d <= 1'b0;
    end else begin
      if (ena) begin
        xs <= x;
        ys <= y;
      end
      ena_d <= ena;
    end
  end

  assign cap = ena_d;
`else
  assign xs  = x;
  assign ys  = y;
  assign cap = ena;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf2m8_mul_core u_core (
      .a (xs),
      .b (ys[8*i +: 8]),
      .p (prod[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      z <= '0;
    else if (cap)
      z <= prod;
  end

endmodule

// File: tb/tb_gf2m8_mul_lanes.sv
// Random and directed bench for gf2m8_mul_lanes.
// Reference products come from log/antilog tables of alpha.
module tb_gf2m8_mul_lanes;

  localparam int L = 5;
`ifdef GF2M8_MUL_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk;
  logic           rstn;
  logic           ena;
  logic [7:0]     x;
  logic [8*L-1:0] y;
  logic [8*L-1:0] z;

  gf2m8_mul_lanes #(.LANES(L)) dut (
    .clk  (clk),
    .rstn (rstn),
    .ena  (ena),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  int exp_t [0:254];
  int log_t [0:255];

  function automatic logic [7:0] ref_mul(input logic [7:0] a,
                                         input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // expected state of the output register(s)
  logic [7:0] mz [L];
`ifdef GF2M8_MUL_PIPE2_EN
  logic [7:0] sx;
  logic [7:0] sy [L];
  logic       se;
`endif

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < L; i++) mz[i] <= 8'h00;
`ifdef GF2M8_MUL_PIPE2_EN
      sx <= 8'h00;
      se <= 1'b0;
      for (int i = 0; i < L; i++) sy[i] <= 8'h00;
`endif
    end else begin
`ifdef GF2M8_MUL_PIPE2_EN
      if (ena) begin
        sx <= x;
        for (int i = 0; i < L; i++) sy[i] <= y[8*i +: 8];
      end
      se <= ena;
      if (se)
        for (int i = 0; i < L; i++) mz[i] <= ref_mul(sx, sy[i]);
`else
      if (ena)
        for (int i = 0; i < L; i++) mz[i] <= ref_mul(x, y[8*i +: 8]);
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [8*L-1:0] ev;
      for (int i = 0; i < L; i++) ev[8*i +: 8] = mz[i];
      n_chk++;
      if (z !== ev) begin
        n_fail++;
        $display("FAIL model_z t=%0t: got %h expected %h", $time, z, ev);
      end
    end
  end

  function automatic logic [8*L-1:0] rnd_y();
    logic [8*L-1:0] v;
    for (int i = 0; i < L; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [8*L-1:0] pack5(input logic [7:0] a0,
    input logic [7:0] a1, input logic [7:0] a2,
    input logic [7:0] a3, input logic [7:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic wait_lat();
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    int e;
    logic [8*L-1:0] v;
    e = 1;
    for (int k = 0; k < 255; k++) begin
      exp_t[k] = e;
      log_t[e] = k;
      e = e << 1;
      if (e & 256) e = e ^ 'h11D;
    end
    log_t[0] = 0;

    check("alpha254", exp_t[254], 'h8E);
    check("inv_2_8e", ref_mul(8'h02, 8'h8E), 'h01);
    check("m02x80", ref_mul(8'h02, 8'h80), 'h1D);
    check("m80x80", ref_mul(8'h80, 8'h80), 'h13);
    check("m03x03", ref_mul(8'h03, 8'h03), 'h05);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      check("commute", ref_mul(a, b), ref_mul(b, a));
    end

    rstn = 1'b0; ena = 1'b1; x = 8'hFF; y = '1;
    @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    check("reset_z", int'(z), 0);

    rstn = 1'b1;
    wait_lat();
    check("rel_l0", int'(z[7:0]), ref_mul(8'hFF, 8'hFF));

    x = 8'h02; y = pack5(8'h80, 8'h8E, 8'h01, 8'h00, 8'h03);
    wait_lat();
    v = pack5(8'h1D, 8'h01, 8'h02, 8'h00, 8'h06);
    check("known5", int'(z), int'(v));

    x = 8'h80; y = pack5(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_lat();
    check("m80_dut", int'(z[7:0]), 'h13);

    x = 8'h03; y = pack5(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_lat();
    check("m03_dut", int'(z[7:0]), 'h05);

    x = 8'h01; y = pack5(8'hA5, 8'h5A, 8'hFF, 8'h3C, 8'h81);
    wait_lat();
    check("pass1", int'(z), int'(y));

    x = 8'h02; y = pack5(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_lat();
    ena = 1'b0; x = 8'h80;
    repeat (3) @(negedge clk);
    check("hold_z0", int'(z[7:0]), 'h1D);
    ena = 1'b1;
    wait_lat();
    check("after_hold", int'(z[7:0]), 'h13);

    for (int k = 0; k < 200; k++) begin
      ena = 1'($urandom_range(0, 3) != 0);
      x = 8'($urandom);
      y = rnd_y();
      @(negedge clk);
    end

    ena = 1'b1;
    for (int k = 0; k < 4; k++) begin
      x = 8'($urandom); y = rnd_y();
      @(negedge clk);
    end
    rstn = 1'b0; x = 8'($urandom); y = rnd_y();
    @(negedge clk);
    check("mid_reset", int'(z), 0);
    rstn = 1'b1;
    x = 8'h02; y = pack5(8'h80, 8'h8E, 8'h01, 8'h00, 8'h03);
    wait_lat();
    check("post_reset", int'(z[15:0]), 'h011D);

    ena = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        x = 8'(a);
        y = rnd_y();
        y[7:0] = 8'(b);
        @(negedge clk);
      end
    end
    repeat (LAT) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
